// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, response owner tags, size codes.
package dmem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StForce = 2'b01,
        StLock  = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        TagNone = 2'b00,
        TagPipe = 2'b01,
        TagLd   = 2'b10
    } resp_tag_e;

    typedef enum logic [1:0] {
        SizeB = 2'b00,
        SizeH = 2'b01,
        SizeW = 2'b10,
        SizeD = 2'b11
    } mem_size_e;

    localparam int unsigned DefAddrW     = 64;
    localparam int unsigned DefDataW     = 64;
    localparam int unsigned DefStarveMax = 4;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of pipeline, loader and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the requesters'/memory's view.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) ();

    logic              pipe_rd;
    logic              pipe_wr;
    logic [1:0]        pipe_size;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_stall;
    logic              pipe_rvalid;
    logic [DATA_W-1:0] pipe_rdata;

    logic              ld_req;
    logic              ld_we;
    logic              ld_lock;
    logic [1:0]        ld_size;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  pipe_rd, pipe_wr, pipe_size, pipe_addr, pipe_wdata,
        output pipe_stall, pipe_rvalid, pipe_rdata,
        input  ld_req, ld_we, ld_lock, ld_size, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output pipe_rd, pipe_wr, pipe_size, pipe_addr, pipe_wdata,
        input  pipe_stall, pipe_rvalid, pipe_rdata,
        output ld_req, ld_we, ld_lock, ld_size, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the MEM stage (priority) and the loader,
// with starvation forcing, a loader lock mode, and owner-tagged 1-cycle read return.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned STARVE_MAX = DefStarveMax
) (
    input logic               clk,
    input logic               rst,
    dmem_port_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

    arb_state_e      state_q, state_d;
    resp_tag_e       resp_tag_q, resp_tag_d;
    logic [CntW-1:0] starve_q, starve_d;

    logic pipe_req;
    logic pipe_win;
    logic ld_win;

    // Winner selection; left ungated by reset since it only feeds held flops and gated outputs.
    always_comb begin
        pipe_req = bus.pipe_rd | bus.pipe_wr;
        pipe_win = 1'b0;
        ld_win   = 1'b0;
        case (state_q)
            StRun: begin
                pipe_win = pipe_req;
                ld_win   = bus.ld_req & ~pipe_req;
            end
            StForce, StLock: begin
                ld_win = bus.ld_req;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d   = starve_q;
        state_d    = state_q;
        resp_tag_d = TagNone;

        if (ld_win) begin
            starve_d = '0;
        end else if (bus.ld_req && starve_q != CntMax) begin
            starve_d = starve_q + 1'b1;
        end

        case (state_q)
            StRun: begin
                if (ld_win) begin
                    state_d = bus.ld_lock ? StLock : StRun;
                end else if (starve_d == CntMax) begin
                    state_d = StForce;
                end
            end
            StForce: begin
                if (ld_win) begin
                    state_d = bus.ld_lock ? StLock : StRun;
                end
            end
            StLock: begin
                // A request arriving with ld_lock low is still served before leaving.
                if (!bus.ld_lock) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase

        if (pipe_win && !bus.pipe_wr) begin
            resp_tag_d = TagPipe;
        end else if (ld_win && !bus.ld_we) begin
            resp_tag_d = TagLd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StRun;
            starve_q   <= '0;
            resp_tag_q <= TagNone;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            resp_tag_q <= resp_tag_d;
        end
    end

    always_comb begin
        bus.pipe_stall  = 1'b0;
        bus.ld_gnt      = 1'b0;
        bus.mem_en      = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_size    = 2'b00;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.pipe_rvalid = 1'b0;
        bus.pipe_rdata  = '0;
        bus.ld_rvalid   = 1'b0;
        bus.ld_rdata    = '0;

        // Outputs are forced quiet while reset is held, even with requests pending.
        if (rst) begin
            bus.pipe_stall = pipe_req & ~pipe_win;
            bus.ld_gnt     = ld_win;
            if (pipe_win) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.pipe_wr;
                bus.mem_size  = bus.pipe_size;
                bus.mem_addr  = bus.pipe_addr;
                bus.mem_wdata = bus.pipe_wdata;
            end else if (ld_win) begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = bus.ld_we;
                bus.mem_size  = bus.ld_size;
                bus.mem_addr  = bus.ld_addr;
                bus.mem_wdata = bus.ld_wdata;
            end
        end

        if (resp_tag_q == TagPipe) begin
            bus.pipe_rvalid = 1'b1;
            bus.pipe_rdata  = bus.mem_rdata;
        end else if (resp_tag_q == TagLd) begin
            bus.ld_rvalid = 1'b1;
            bus.ld_rdata  = bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench: per-cycle comparison against a behavioural arbitration model,
// plus directed scenarios with literal expectations.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int STARVE_MAX = 4;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    dmem_port_arbiter #(
        .ADDR_W    (64),
        .DATA_W    (64),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: mode 0 = pipeline has priority, 1 = loader forced, 2 = loader owns.
    int   m_mode;
    int   m_starve;
    int   m_owner;  // 0 none, 1 pipeline, 2 loader
    int   m_starve_nx;
    logic m_preq, m_pg, m_lg;

    always_comb begin
        m_preq = bus.pipe_rd | bus.pipe_wr;
        m_pg   = m_preq && (m_mode == 0);
        m_lg   = bus.ld_req && !(m_mode == 0 && m_preq);
        if (m_lg)            m_starve_nx = 0;
        else if (bus.ld_req) m_starve_nx = (m_starve >= STARVE_MAX) ? STARVE_MAX : m_starve + 1;
        else                 m_starve_nx = m_starve;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode   <= 0;
            m_starve <= 0;
            m_owner  <= 0;
        end else begin
            m_starve <= m_starve_nx;
            m_owner  <= (m_pg && !bus.pipe_wr) ? 1 : ((m_lg && !bus.ld_we) ? 2 : 0);
            if (m_mode == 0) begin
                if (m_lg) m_mode <= bus.ld_lock ? 2 : 0;
                else if (m_starve_nx == STARVE_MAX) m_mode <= 1;
            end else if (m_mode == 1) begin
                if (m_lg) m_mode <= bus.ld_lock ? 2 : 0;
            end else begin
                if (!bus.ld_lock) m_mode <= 0;
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic        e_stall, e_gnt, e_en, e_we, e_prv, e_lrv;
        logic [1:0]  e_size;
        logic [63:0] e_addr, e_wdata, e_prd, e_lrd;
        {e_stall, e_gnt, e_en, e_we, e_prv, e_lrv} = '0;
        e_size = 2'b00;
        {e_addr, e_wdata, e_prd, e_lrd} = '0;
        if (rst) begin
            e_stall = m_preq && !m_pg;
            e_gnt   = m_lg;
            if (m_pg) begin
                e_en = 1'b1; e_we = bus.pipe_wr; e_size = bus.pipe_size;
                e_addr = bus.pipe_addr; e_wdata = bus.pipe_wdata;
            end else if (m_lg) begin
                e_en = 1'b1; e_we = bus.ld_we; e_size = bus.ld_size;
                e_addr = bus.ld_addr; e_wdata = bus.ld_wdata;
            end
            if (m_owner == 1) begin e_prv = 1'b1; e_prd = bus.mem_rdata; end
            if (m_owner == 2) begin e_lrv = 1'b1; e_lrd = bus.mem_rdata; end
        end
        chk("model pipe_stall",  64'(bus.pipe_stall),  64'(e_stall));
        chk("model ld_gnt",      64'(bus.ld_gnt),      64'(e_gnt));
        chk("model mem_en",      64'(bus.mem_en),      64'(e_en));
        chk("model mem_we",      64'(bus.mem_we),      64'(e_we));
        chk("model mem_size",    64'(bus.mem_size),    64'(e_size));
        chk("model mem_addr",    bus.mem_addr,         e_addr);
        chk("model mem_wdata",   bus.mem_wdata,        e_wdata);
        chk("model pipe_rvalid", 64'(bus.pipe_rvalid), 64'(e_prv));
        chk("model pipe_rdata",  bus.pipe_rdata,       e_prd);
        chk("model ld_rvalid",   64'(bus.ld_rvalid),   64'(e_lrv));
        chk("model ld_rdata",    bus.ld_rdata,         e_lrd);
    end

    task automatic idle();
        bus.pipe_rd = 1'b0; bus.pipe_wr = 1'b0; bus.pipe_size = SizeD;
        bus.pipe_addr = '0; bus.pipe_wdata = '0;
        bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_lock = 1'b0; bus.ld_size = SizeD;
        bus.ld_addr = '0; bus.ld_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both sides request continuously: 4 pipeline grants, forced loader grant, pipeline again.
    task automatic starve_seq(input string tag);
        for (int i = 0; i < 6; i++) begin
            bus.pipe_rd   = 1'b1;
            bus.pipe_addr = 64'h100 + 64'(i);
            bus.ld_req    = (i < 5);
            bus.ld_we     = 1'b1;
            bus.ld_addr   = 64'h200;
            bus.ld_wdata  = 64'h55;
            #2;
            chk({tag, " ld_gnt"},     64'(bus.ld_gnt),     64'(i == 4));
            chk({tag, " pipe_stall"}, 64'(bus.pipe_stall), 64'(i == 4));
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Pipe read, data returned next cycle
        bus.pipe_rd = 1'b1; bus.pipe_addr = 64'h8;
        #2;
        chk("t1 mem_en", 64'(bus.mem_en), 64'd1);
        chk("t1 pipe_stall", 64'(bus.pipe_stall), 64'd0);
        chk("t1 mem_addr", bus.mem_addr, 64'h8);
        tick();
        idle(); bus.mem_rdata = 64'hDEADBEEF;
        #2;
        chk("t1 pipe_rvalid", 64'(bus.pipe_rvalid), 64'd1);
        chk("t1 pipe_rdata", bus.pipe_rdata, 64'hDEADBEEF);
        chk("t1 ld_rvalid", 64'(bus.ld_rvalid), 64'd0);
        tick();

        // Pipe byte write: no read return afterwards
        bus.pipe_wr = 1'b1; bus.pipe_size = SizeB; bus.pipe_addr = '0; bus.pipe_wdata = 64'hAA;
        #2;
        chk("t6 mem_en", 64'(bus.mem_en), 64'd1);
        chk("t6 mem_we", 64'(bus.mem_we), 64'd1);
        chk("t6 mem_size", 64'(bus.mem_size), 64'd0);
        chk("t6 mem_wdata", bus.mem_wdata, 64'hAA);
        tick();
        idle(); bus.mem_rdata = 64'h5;
        #2;
        chk("t6 pipe_rvalid", 64'(bus.pipe_rvalid), 64'd0);
        chk("t6 ld_rvalid", 64'(bus.ld_rvalid), 64'd0);
        tick();

        // Back-to-back reads from different owners
        bus.pipe_rd = 1'b1; bus.pipe_addr = 64'h10;
        tick();
        idle(); bus.ld_req = 1'b1; bus.ld_addr = 64'h20; bus.mem_rdata = 64'h1111;
        #2;
        chk("t4 ld_gnt", 64'(bus.ld_gnt), 64'd1);
        chk("t4 pipe_rvalid", 64'(bus.pipe_rvalid), 64'd1);
        chk("t4 pipe_rdata", bus.pipe_rdata, 64'h1111);
        tick();
        idle(); bus.mem_rdata = 64'h2222;
        #2;
        chk("t4 ld_rvalid", 64'(bus.ld_rvalid), 64'd1);
        chk("t4 ld_rdata", bus.ld_rdata, 64'h2222);
        chk("t4 pipe_rdata", bus.pipe_rdata, 64'h0);
        tick();

        starve_seq("t2");

        // Forced locked write, three locked reads, then lock release
        for (int i = 0; i < 5; i++) begin
            bus.pipe_rd = 1'b1; bus.pipe_addr = 64'h300;
            bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_lock = 1'b1;
            bus.ld_addr = 64'hD; bus.ld_wdata = 64'hAB;
            #2;
            chk("t3 ld_gnt", 64'(bus.ld_gnt), 64'(i == 4));
            if (i == 4) begin
                chk("t3 wr stall", 64'(bus.pipe_stall), 64'd1);
                chk("t3 wr addr", bus.mem_addr, 64'hD);
                chk("t3 wr data", bus.mem_wdata, 64'hAB);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            bus.ld_we = 1'b0; bus.ld_addr = 64'h20 + 64'(k); bus.mem_rdata = 64'h100 + 64'(k);
            #2;
            chk("t3 rd gnt", 64'(bus.ld_gnt), 64'd1);
            chk("t3 rd stall", 64'(bus.pipe_stall), 64'd1);
            chk("t3 ld_rvalid", 64'(bus.ld_rvalid), 64'(k > 0));
            tick();
        end
        bus.ld_req = 1'b0; bus.ld_lock = 1'b0; bus.mem_rdata = 64'h103;
        #2;
        chk("t3 exit stall", 64'(bus.pipe_stall), 64'd1);
        chk("t3 last ld_rdata", bus.ld_rdata, 64'h103);
        tick();
        #2;
        chk("t3 run stall", 64'(bus.pipe_stall), 64'd0);
        chk("t3 run ld_rdata", bus.ld_rdata, 64'h0);
        tick();

        // Lock dropped while requesting: served, then back to pipeline priority
        idle(); bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_lock = 1'b1;
        #2;
        chk("t7 enter gnt", 64'(bus.ld_gnt), 64'd1);
        tick();
        bus.ld_we = 1'b0; bus.ld_lock = 1'b0; bus.pipe_rd = 1'b1;
        #2;
        chk("t7 drop gnt", 64'(bus.ld_gnt), 64'd1);
        chk("t7 drop stall", 64'(bus.pipe_stall), 64'd1);
        tick();
        bus.ld_req = 1'b0;
        #2;
        chk("t7 run stall", 64'(bus.pipe_stall), 64'd0);
        tick();

        // Reset the cycle after a granted read
        idle(); bus.pipe_rd = 1'b1; bus.pipe_addr = 64'h40;
        #2;
        chk("t5 mem_en", 64'(bus.mem_en), 64'd1);
        tick();
        rst = 1'b0; bus.ld_req = 1'b1; bus.mem_rdata = 64'h77;
        #2;
        chk("t5 rst pipe_rvalid", 64'(bus.pipe_rvalid), 64'd0);
        chk("t5 rst pipe_rdata", bus.pipe_rdata, 64'h0);
        chk("t5 rst mem_en", 64'(bus.mem_en), 64'd0);
        chk("t5 rst pipe_stall", 64'(bus.pipe_stall), 64'd0);
        chk("t5 rst ld_gnt", 64'(bus.ld_gnt), 64'd0);
        tick();
        rst = 1'b1; idle();
        #2;
        chk("t5 post pipe_rvalid", 64'(bus.pipe_rvalid), 64'd0);
        chk("t5 post ld_rvalid", 64'(bus.ld_rvalid), 64'd0);
        tick();
        starve_seq("t5");

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
